xf100_lsu_ram_ctrl: RTL

XF100_LSU_RAM_CTRL -- requirements
Module: xf100_lsu_ram_ctrl

---
 rtl/xf100_lsu_ram_ctrl_pkg.sv | 32 +++
 rtl/xf100_lsu_ram_ctrl_align.sv | 41 ++++
 rtl/xf100_lsu_ram_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/xf100_lsu_ram_ctrl_pkg.sv
// Shared encodings for the LSU data-RAM controller: access sizes, FSM states, lane masks.
`ifndef XF100_DATA_RAM_AW
`define XF100_DATA_RAM_AW 16
`endif
`ifndef XF100_RFIDX_WIDTH
`define XF100_RFIDX_WIDTH 5
`endif

package xf100_lsu_ram_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_WR2  = 3'd3,
        ST_WB   = 3'd4
    } lsu_state_e;

    // Byte lanes touched by an access of the given size, before shifting by offset.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/xf100_lsu_ram_ctrl_align.sv
// Combinational lane logic: byte enables over a two-word window, store rotation, load extract/extend.
module xf100_lsu_align
    import xf100_lsu_ram_ctrl_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rdat,
    output logic [3:0]  o_be_lo,
    output logic [3:0]  o_be_hi,
    output logic [31:0] o_wdat_lo,
    output logic [31:0] o_wdat_hi,
    output logic        o_mis,
    output logic [31:0] o_ldata
);
    logic [7:0]  w_be;
    logic [63:0] w_wrot;
    logic [63:0] w_rrot;
    logic [4:0]  w_sh;

    assign w_sh      = {i_off, 3'b000};
    assign w_be      = {4'b0000, size_mask(i_size)} << i_off;
    assign w_wrot    = {32'h0, i_wdata} << w_sh;
    assign w_rrot    = i_rdat >> w_sh;
    assign o_be_lo   = w_be[3:0];
    assign o_be_hi   = w_be[7:4];
    assign o_wdat_lo = w_wrot[31:0];
    assign o_wdat_hi = w_wrot[63:32];
    // Any lane spilling past byte 3 means the access straddles two words.
    assign o_mis     = |w_be[7:4];

    always_comb begin
        case (i_size)
            SZ_BYTE: o_ldata = {{24{~i_uns & w_rrot[7]}}, w_rrot[7:0]};
            SZ_HALF: o_ldata = {{16{~i_uns & w_rrot[15]}}, w_rrot[15:0]};
            default: o_ldata = w_rrot[31:0];
        endcase
    end

endmodule

// File: rtl/xf100_lsu_ram_ctrl.sv
// LSU data-RAM controller: splits misaligned accesses into two word accesses and
// returns load results through a registered writeback port.
`ifndef XF100_DATA_RAM_AW
`define XF100_DATA_RAM_AW 16
`endif
`ifndef XF100_RFIDX_WIDTH
`define XF100_RFIDX_WIDTH 5
`endif

module xf100_lsu_ram_ctrl
    import xf100_lsu_ram_ctrl_pkg::*;
#(
    parameter int AW = `XF100_DATA_RAM_AW,
    parameter int RW = `XF100_RFIDX_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wen,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    input  logic [RW-1:0] req_rdidx,
    output logic          ram_cs,
    output logic          ram_wen,
    output logic [AW-3:0] ram_addr,
    output logic [3:0]    ram_be,
    output logic [31:0]   ram_wdat,
    input  logic [31:0]   ram_rdat,
    output logic          wbck_en,
    output logic [31:0]   wbck_data,
    output logic [RW-1:0] wbck_rdidx,
    input  logic          wbck_ready
);
    localparam int WW = AW - 2;

    lsu_state_e    r_state;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [31:0]   r_wdata;
    logic [RW-1:0] r_rdidx;
    logic [WW-1:0] r_widx1;
    logic [31:0]   r_rdat_lo;
    logic          r_wbck_en;
    logic [31:0]   r_wbck_data;
    logic [RW-1:0] r_wbck_rdidx;

    logic          w_idle;
    logic [1:0]    w_off;
    logic [1:0]    w_size;
    logic          w_uns;
    logic [31:0]   w_wdata;
    logic [63:0]   w_rdat;
    logic [3:0]    w_be_lo;
    logic [3:0]    w_be_hi;
    logic [31:0]   w_wdat_lo;
    logic [31:0]   w_wdat_hi;
    logic          w_mis;
    logic [31:0]   w_ldata;

    // The aligner sees the live request in IDLE and the captured one afterwards.
    assign w_idle  = (r_state == ST_IDLE);
    assign w_off   = w_idle ? req_addr[1:0] : r_off;
    assign w_size  = w_idle ? req_size : r_size;
    assign w_uns   = w_idle ? req_unsigned : r_uns;
    assign w_wdata = w_idle ? req_wdata : r_wdata;
    assign w_rdat  = (r_state == ST_RD2) ? {ram_rdat, r_rdat_lo} : {32'h0, ram_rdat};

    xf100_lsu_align u_align (
        .i_off     (w_off),
        .i_size    (w_size),
        .i_uns     (w_uns),
        .i_wdata   (w_wdata),
        .i_rdat    (w_rdat),
        .o_be_lo   (w_be_lo),
        .o_be_hi   (w_be_hi),
        .o_wdat_lo (w_wdat_lo),
        .o_wdat_hi (w_wdat_hi),
        .o_mis     (w_mis),
        .o_ldata   (w_ldata)
    );

    assign req_ready  = w_idle;
    assign wbck_en    = r_wbck_en;
    assign wbck_data  = r_wbck_data;
    assign wbck_rdidx = r_wbck_rdidx;

    always_comb begin
        ram_cs   = 1'b0;
        ram_wen  = 1'b0;
        ram_addr = req_addr[AW-1:2];
        ram_be   = w_be_lo;
        ram_wdat = w_wdat_lo;
        case (r_state)
            ST_IDLE: begin
                ram_cs  = req_valid;
                ram_wen = req_wen;
            end
            ST_RD1: begin
                ram_cs   = w_mis;
                ram_addr = r_widx1;
                ram_be   = w_be_hi;
            end
            ST_WR2: begin
                ram_cs   = 1'b1;
                ram_wen  = 1'b1;
                ram_addr = r_widx1;
                ram_be   = w_be_hi;
                ram_wdat = w_wdat_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_off        <= '0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_wdata      <= '0;
            r_rdidx      <= '0;
            r_widx1      <= '0;
            r_rdat_lo    <= '0;
            r_wbck_en    <= 1'b0;
            r_wbck_data  <= '0;
            r_wbck_rdidx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_off   <= req_addr[1:0];
                    r_size  <= req_size;
                    r_uns   <= req_unsigned;
                    r_wdata <= req_wdata;
                    r_rdidx <= req_rdidx;
                    r_widx1 <= req_addr[AW-1:2] + WW'(1);
                    if (!req_wen)   r_state <= ST_RD1;
                    else if (w_mis) r_state <= ST_WR2;
                end
                ST_RD1: begin
                    r_rdat_lo <= ram_rdat;
                    if (w_mis) begin
                        r_state <= ST_RD2;
                    end else begin
                        r_wbck_en    <= 1'b1;
                        r_wbck_data  <= w_ldata;
                        r_wbck_rdidx <= r_rdidx;
                        r_state      <= ST_WB;
                    end
                end
                ST_RD2: begin
                    r_wbck_en    <= 1'b1;
                    r_wbck_data  <= w_ldata;
                    r_wbck_rdidx <= r_rdidx;
                    r_state      <= ST_WB;
                end
                ST_WR2: r_state <= ST_IDLE;
                ST_WB: if (wbck_ready) begin
                    r_wbck_en <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
